// File: rtl/y_sig_pkg.sv
// Shared defaults and FSM encoding for the y-bus signature compactor.
package y_sig_pkg;

  localparam int          Y_W_DEF   = 350;
  localparam int          SIG_W_DEF = 32;
  localparam logic [31:0] POLY_DEF  = 32'h04C1_1DB7;
  localparam logic [31:0] SEED_DEF  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } sig_state_e;

endpackage

// File: rtl/y_fold_xor.sv
// Folds a wide result vector down to one signature word: the vector is
// zero-padded to whole SIG_W words and all words are XORed together.
module y_fold_xor #(
  parameter int Y_W   = 350,
  parameter int SIG_W = 32
) (
  input  logic [Y_W-1:0]   y_in,
  output logic [SIG_W-1:0] fold
);

  localparam int N_WORDS = (Y_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W   = N_WORDS * SIG_W;

  logic [PAD_W-1:0] pad_s;

  // Zero-pad the input and XOR-reduce it word by word.
  always_comb begin
    pad_s          = '0;
    pad_s[Y_W-1:0] = y_in;
    fold           = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      fold = fold ^ pad_s[k*SIG_W +: SIG_W];
    end
  end

endmodule

// File: rtl/y_sig_compactor.sv
// Captures a MISR signature of the folded upstream result bus over a
// programmable window, after a fixed warm-up, and holds it for a consumer.
module y_sig_compactor
  import y_sig_pkg::*;
#(
  parameter int               Y_W    = Y_W_DEF,
  parameter int               SIG_W  = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_DEF),
  parameter int               WARMUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Y_W-1:0]   y_in,
  input  logic             start,
  input  logic [15:0]      win_len,
  output logic             busy,
  output logic [SIG_W-1:0] sig,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [15:0]      cyc_cnt
);

  localparam logic [15:0] WARM_LAST = (WARMUP > 0) ? 16'(WARMUP - 1) : 16'd0;

  sig_state_e       state_r, state_s;
  logic [SIG_W-1:0] sig_r, sig_s;
  logic [15:0]      cyc_cnt_r, cyc_cnt_s;
  logic [15:0]      warm_cnt_r, warm_cnt_s;
  logic [15:0]      win_len_r, win_len_s;
  logic             sig_valid_r;
  logic             busy_r;
  logic [SIG_W-1:0] fold_s;

  // One MISR shift with polynomial feedback, then XOR in the folded data.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                 input logic [SIG_W-1:0] din);
    logic [SIG_W-1:0] fb;
    fb = cur[SIG_W-1] ? POLY : '0;
    return {cur[SIG_W-2:0], 1'b0} ^ fb ^ din;
  endfunction

  y_fold_xor #(
    .Y_W   (Y_W),
    .SIG_W (SIG_W)
  ) u_fold (
    .y_in (y_in),
    .fold (fold_s)
  );

  // Next-state, signature and counter update logic.
  always_comb begin
    state_s    = state_r;
    sig_s      = sig_r;
    cyc_cnt_s  = cyc_cnt_r;
    warm_cnt_s = warm_cnt_r;
    win_len_s  = win_len_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          win_len_s  = win_len;
          sig_s      = SEED;
          cyc_cnt_s  = 16'd0;
          warm_cnt_s = 16'd0;
          if (WARMUP != 0) begin
            state_s = ST_WARM;
          end else if (win_len == 16'd0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ACC;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WARM: begin
        if (warm_cnt_r == WARM_LAST) begin
          warm_cnt_s = 16'd0;
          state_s    = (win_len_r == 16'd0) ? ST_DONE : ST_ACC;
        end else begin
          warm_cnt_s = warm_cnt_r + 16'd1;
        end
      end
      ST_ACC: begin
        sig_s     = misr_step(sig_r, fold_s);
        cyc_cnt_s = (cyc_cnt_r == 16'hFFFF) ? cyc_cnt_r : cyc_cnt_r + 16'd1;
        if (cyc_cnt_r == win_len_r - 16'd1) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_DONE: begin
        if (sig_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      sig_r       <= '0;
      cyc_cnt_r   <= 16'd0;
      warm_cnt_r  <= 16'd0;
      win_len_r   <= 16'd0;
      sig_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      sig_r       <= sig_s;
      cyc_cnt_r   <= cyc_cnt_s;
      warm_cnt_r  <= warm_cnt_s;
      win_len_r   <= win_len_s;
      sig_valid_r <= (state_s == ST_DONE);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  assign sig       = sig_r;
  assign cyc_cnt   = cyc_cnt_r;
  assign sig_valid = sig_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_y_sig_compactor.sv
// Scoreboard bench: two compactor instances (seed 0 / no warm-up, and the
// default seed / warm-up of 4) checked against an independent bit-level model.
module tb_y_sig_compactor;

  typedef struct {
    logic [31:0] sig;
    logic [15:0] cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [349:0] y_in;
  logic [15:0]  win_len;
  logic         start0, start1, rdy0, rdy1;
  logic         busy0, busy1, valid0, valid1;
  logic [31:0]  sig0, sig1;
  logic [15:0]  cyc0, cyc1;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  y_sig_compactor #(.SEED(32'h0000_0000), .WARMUP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .start(start0), .win_len(win_len),
    .busy(busy0), .sig(sig0), .sig_valid(valid0), .sig_ready(rdy0), .cyc_cnt(cyc0)
  );

  y_sig_compactor dut1 (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .start(start1), .win_len(win_len),
    .busy(busy1), .sig(sig1), .sig_valid(valid1), .sig_ready(rdy1), .cyc_cnt(cyc1)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_fold(input logic [349:0] y);
    logic [31:0] f;
    f = 32'h0;
    for (int i = 0; i < 350; i++) f[i % 32] = f[i % 32] ^ y[i];
    return f;
  endfunction

  function automatic logic [31:0] tb_misr(input logic [31:0] s, input logic [31:0] f);
    logic [31:0] n;
    n = {s[30:0], 1'b0};
    if (s[31]) n = n ^ 32'h04C1_1DB7;
    return n ^ f;
  endfunction

  function automatic logic [349:0] gen_y(input int pat);
    logic [351:0] v;
    v = '0;
    case (pat)
      1: v[1] = 1'b1;
      2: begin v[0] = 1'b1; v[32] = 1'b1; end
      3: for (int k = 0; k < 11; k++) v[k*32 +: 32] = $urandom;
      default: v = '0;
    endcase
    return v[349:0];
  endfunction

  function automatic logic get_valid(input int d); return (d != 0) ? valid1 : valid0; endfunction
  function automatic logic get_busy(input int d);  return (d != 0) ? busy1  : busy0;  endfunction
  function automatic logic [31:0] get_sig(input int d); return (d != 0) ? sig1 : sig0; endfunction
  function automatic logic [15:0] get_cyc(input int d); return (d != 0) ? cyc1 : cyc0; endfunction

  task automatic drive_start(input int d, input logic v);
    if (d != 0) start1 = v; else start0 = v;
  endtask

  task automatic drive_ready(input int d, input logic v);
    if (d != 0) rdy1 = v; else rdy0 = v;
  endtask

  // One capture run: start, feed data while modelling, check latency and
  // result, optionally stall in DONE with a stray start, then hand shake.
  task automatic run_case(input int d, input logic [15:0] len, input int pat,
                          input int hold, input bit sync, input string tag);
    int          w;
    logic [31:0] m;
    logic [31:0] held;
    logic [349:0] y;
    bit          early, stable;
    exp_t        e;
    w = (d != 0) ? 4 : 0;
    m = (d != 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
    if (sync) begin @(posedge clk); #1; end
    y_in = gen_y(pat);
    win_len = len;
    drive_start(d, 1'b1);
    @(posedge clk); #1;
    drive_start(d, 1'b0);
    win_len = 16'($urandom);
    early = 1'b0;
    for (int c = 1; c <= w + int'(len); c++) begin
      if (get_valid(d)) early = 1'b1;
      y = gen_y(pat);
      y_in = y;
      if (c > w) m = tb_misr(m, tb_fold(y));
      @(posedge clk); #1;
    end
    e.sig = m;
    e.cyc = len;
    sb_q.push_back(e);
    y_in = gen_y(3);
    check_val({tag, "_early"}, 64'(early), 64'(1'b0));
    check_val({tag, "_valid"}, 64'(get_valid(d)), 64'(1'b1));
    check_val({tag, "_busy"}, 64'(get_busy(d)), 64'(1'b1));
    e = sb_q.pop_front();
    check_val({tag, "_sig"}, 64'(get_sig(d)), 64'(e.sig));
    check_val({tag, "_cyc"}, 64'(get_cyc(d)), 64'(e.cyc));
    held = get_sig(d);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      y_in = gen_y(3);
      drive_start(d, (i == hold / 2));
      @(posedge clk); #1;
      if (get_sig(d) !== held || get_valid(d) !== 1'b1 || get_cyc(d) !== len) stable = 1'b0;
    end
    drive_start(d, 1'b0);
    if (hold > 0) check_val({tag, "_hold"}, 64'(stable), 64'(1'b1));
    drive_ready(d, 1'b1);
    drive_start(d, 1'b1);
    @(posedge clk); #1;
    drive_ready(d, 1'b0);
    drive_start(d, 1'b0);
    check_val({tag, "_hs_valid"}, 64'(get_valid(d)), 64'(1'b0));
    check_val({tag, "_hs_busy"}, 64'(get_busy(d)), 64'(1'b0));
    check_val({tag, "_idle_sig"}, 64'(get_sig(d)), 64'(e.sig));
    @(posedge clk); #1;
    check_val({tag, "_idle_busy"}, 64'(get_busy(d)), 64'(1'b0));
    check_val({tag, "_idle_cyc"}, 64'(get_cyc(d)), 64'(e.cyc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    y_in = '0;
    win_len = 16'd0;
    #1;
    check_val("rst_sig0", 64'(sig0), 64'(32'h0));
    check_val("rst_valid0", 64'(valid0), 64'(1'b0));
    check_val("rst_busy0", 64'(busy0), 64'(1'b0));
    check_val("rst_cyc0", 64'(cyc0), 64'(16'h0));
    check_val("rst_sig1", 64'(sig1), 64'(32'h0));
    check_val("rst_valid1", 64'(valid1), 64'(1'b0));
    check_val("rst_busy1", 64'(busy1), 64'(1'b0));
    check_val("rst_cyc1", 64'(cyc1), 64'(16'h0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Start coincident with release: first edge must accept it.
    run_case(0, 16'd1, 1, 0, 1'b0, "r034");
    check_val("r034_const", 64'(sig0), 64'(32'h0000_0002));
    run_case(0, 16'd100, 0, 0, 1'b1, "r035");
    check_val("r035_const", 64'(sig0), 64'(32'h0));
    run_case(0, 16'd8, 2, 0, 1'b1, "r036");
    check_val("r036_const", 64'(sig0), 64'(32'h0));
    run_case(0, 16'd5, 3, 0, 1'b1, "d0_rand5");
    run_case(0, 16'd0, 3, 0, 1'b1, "d0_len0");
    run_case(1, 16'd7, 3, 0, 1'b1, "d1_rand7");
    run_case(1, 16'd1, 3, 0, 1'b1, "d1_len1");
    run_case(1, 16'd100, 0, 0, 1'b1, "d1_zero100");
    run_case(1, 16'd3, 3, 20, 1'b1, "r037");

    // Abort a long run mid-accumulation with reset.
    @(posedge clk); #1;
    y_in = gen_y(3);
    win_len = 16'd200;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int c = 1; c <= 54; c++) begin
      y_in = gen_y(3);
      @(posedge clk); #1;
    end
    check_val("r038_pre_cyc", 64'(cyc1), 64'(16'd50));
    check_val("r038_pre_busy", 64'(busy1), 64'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("r038_sig", 64'(sig1), 64'(32'h0));
    check_val("r038_valid", 64'(valid1), 64'(1'b0));
    check_val("r038_busy", 64'(busy1), 64'(1'b0));
    check_val("r038_cyc", 64'(cyc1), 64'(16'h0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_case(1, 16'd0, 3, 0, 1'b0, "r038_len0");
    check_val("r038_seed", 64'(sig1), 64'(32'hFFFF_FFFF));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/y_sig_compactor.md
Y_SIG_COMPACTOR -- requirements
Module: y_sig_compactor

Interface
REQ-001 Parameter Y_W, default 350, width of the upstream result bus consumed each cycle.
REQ-002 Parameter SIG_W, default 32, signature width.
REQ-003 Parameter POLY, default 32'h04C1_1DB7, MISR feedback polynomial.
REQ-004 Parameter SEED, default 32'hFFFF_FFFF, signature value loaded on start.
REQ-005 Parameter WARMUP, default 4, cycles skipped after start before accumulation begins.
REQ-006 clk  input  1  sole clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 y_in  input  Y_W  upstream result vector, sampled every cycle.
REQ-009 start  input  1  single-cycle pulse that begins a capture run.
REQ-010 win_len  input  16  number of accumulated cycles, latched on accepted start.
REQ-011 busy  output  1  high in WARM, ACC and DONE.
REQ-012 sig  output  SIG_W  signature; stable while sig_valid is high.
REQ-013 sig_valid  output  1  signature-ready flag.
REQ-014 sig_ready  input  1  consumer acceptance.
REQ-015 cyc_cnt  output  16  number of cycles accumulated in the current run.

Function
REQ-016 Fold: y_in is zero-padded to a multiple of SIG_W (352 bits at default); fold[j] is the XOR over k of pad[SIG_W*k+j].
REQ-017 MISR step: sig_next = ((sig << 1) ^ (sig[SIG_W-1] ? POLY : 0)) ^ fold.
REQ-018 FSM states are IDLE, WARM, ACC and DONE.
REQ-019 IDLE + start: latch win_len, load sig=SEED, clear cyc_cnt, go to WARM (or to ACC when WARMUP=0).
REQ-020 WARM: count WARMUP cycles and do not update sig; on the last warm cycle, go to ACC.
REQ-021 ACC: each cycle, apply one MISR step and increment cyc_cnt; when cyc_cnt reaches win_len-1, apply the final step and go to DONE.
REQ-022 win_len=0 latched: skip ACC; enter DONE with sig=SEED and cyc_cnt=0.
REQ-023 DONE: sig_valid=1, sig and cyc_cnt frozen; on the sig_valid&&sig_ready cycle, go to IDLE with sig_valid low on the next cycle.
REQ-024 start outside IDLE is ignored, including start coincident with the handshake cycle.
REQ-025 Latency: sig_valid rises exactly WARMUP+win_len cycles after the start cycle.
REQ-026 sig and cyc_cnt stay visible in IDLE until the next accepted start.
REQ-027 cyc_cnt saturates at 16'hFFFF and never wraps.

Reset
REQ-028 rst_n low asynchronously forces IDLE, sig=0, cyc_cnt=0, sig_valid=0, busy=0, warm counter=0.
REQ-029 Reset asserted mid-run aborts the run; no partial signature is presented after release.
REQ-030 The first start is honoured on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package y_sig_pkg holds the Y_W/SIG_W/POLY/SEED defaults and the FSM state enum.
REQ-032 The fold is a combinational sub-module, y_fold_xor (params Y_W, SIG_W); the FSM and MISR live in the top module.
REQ-033 No other sub-modules.

Verification
REQ-034 SEED=0, WARMUP=0, win_len=1, y_in=0 except bit1=1 -> one cycle later sig=32'h0000_0002, sig_valid=1, cyc_cnt=1.
REQ-035 SEED=0, y_in all-zero, win_len=100 -> sig=0 and sig_valid asserted exactly WARMUP+100 cycles after start.
REQ-036 Bits 0 and 32 set in y_in (fold cancels), win_len=8, SEED=0 -> sig=0.
REQ-037 sig_ready held low 20 cycles in DONE with start pulsed -> sig stable, start ignored, IDLE one cycle after sig_ready=1.
REQ-038 rst_n dropped at cyc_cnt=50 of a win_len=200 run -> all outputs 0 immediately; fresh start with win_len=0 -> sig=SEED, sig_valid after WARMUP cycles.
